// File: rtl/acc_sequencer.sv
// Accumulator and LOAD/ADD/SUB/MUL sequencer wrapped around an external WIDTH-bit ripple-carry adder.
// Define ACC_SAT_EN to replace modulo wrap-around with saturating arithmetic.
module acc_sequencer #(
  parameter int WIDTH = 3,
  parameter int OP_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             zero,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  localparam logic [OP_W-1:0] OP_LOAD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(3);

  state_t           state;
  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] opd_q;
  logic [WIDTH-1:0] base_q;
  logic [WIDTH-1:0] cnt_q;

  logic             c_loc;
  logic             sticky;
  logic [WIDTH-1:0] sum_up;
  logic [WIDTH-1:0] sum_dn;
  logic [WIDTH-1:0] acc_nxt;
  logic             carry_nxt;

`ifdef ACC_SAT_EN
  function automatic logic [WIDTH-1:0] sat_ovf(input logic [WIDTH-1:0] s, input logic ovf);
    return ovf ? '1 : s;
  endfunction

  function automatic logic [WIDTH-1:0] sat_borrow(input logic [WIDTH-1:0] s, input logic no_borrow);
    return no_borrow ? s : '0;
  endfunction
`endif

  assign in_ready = (state == S_IDLE) && !rst;

  always_comb begin
    add_a   = acc;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      S_EXEC: begin
        if (op_q == OP_ADD) begin
          add_b = opd_q;
        end else if (op_q == OP_SUB) begin
          add_b   = ~opd_q;
          add_cin = 1'b1;
        end
      end
      S_MUL:   add_b = base_q;
      default: ;
    endcase
  end

  // Carry out of the MSB rebuilt from the MSB operands and sum; the adder's cout is not wired back.
  assign c_loc  = (add_a[WIDTH-1] & add_b[WIDTH-1]) |
                  ((add_a[WIDTH-1] ^ add_b[WIDTH-1]) & ~add_s[WIDTH-1]);
  assign sticky = (state == S_MUL) ? (carry | c_loc) : c_loc;

`ifdef ACC_SAT_EN
  assign sum_up = sat_ovf(add_s, sticky);
  assign sum_dn = sat_borrow(add_s, c_loc);
`else
  assign sum_up = add_s;
  assign sum_dn = add_s;
`endif

  always_comb begin
    acc_nxt   = acc;
    carry_nxt = carry;
    case (state)
      S_EXEC: begin
        case (op_q)
          OP_LOAD: begin
            acc_nxt   = opd_q;
            carry_nxt = 1'b0;
          end
          OP_ADD: begin
            acc_nxt   = sum_up;
            carry_nxt = c_loc;
          end
          OP_SUB: begin
            acc_nxt   = sum_dn;
            carry_nxt = c_loc;
          end
          default: begin
            acc_nxt   = '0;
            carry_nxt = 1'b0;
          end
        endcase
      end
      S_MUL: begin
        acc_nxt   = sum_up;
        carry_nxt = sticky;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= '0;
      opd_q  <= '0;
      base_q <= '0;
      cnt_q  <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      zero   <= 1'b1;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            op_q  <= op;
            opd_q <= operand;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          acc   <= acc_nxt;
          carry <= carry_nxt;
          zero  <= (acc_nxt == '0);
          if (op_q == OP_MUL && opd_q != '0) begin
            base_q <= acc;
            cnt_q  <= opd_q;
            state  <= S_MUL;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_MUL: begin
          acc   <= acc_nxt;
          carry <= carry_nxt;
          zero  <= (acc_nxt == '0);
          cnt_q <= cnt_q - WIDTH'(1);
          if (cnt_q == WIDTH'(1)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
